line_composer: RTL

Expands one text row into 4-bit pixel words for the 1280-pixel line buffer. Each character cell is fetched from the upstream attribute/glyph path, then turned into 16 pixels by applying glyph bits, colours and attributes. The result is written as one 64-bit word per column into the line buffer's write port: address 0..79, 16 pixels × 4 bits. The video scan-out later reads that buffer 4 bits at a time.

---
 rtl/line_composer.sv | 109 ++++++++++
 1 files changed

// File: rtl/line_composer.sv
// Text-row expander: turns one character cell per handshake into a 64-bit word
// of 16 4-bit pixels and writes it to the line buffer, column 0..COLUMNS-1.
module line_composer #(
   parameter int COLUMNS    = 80,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  blink_phase,
   input  logic                  src_valid,
   output logic                  src_ready,
   input  logic [15:0]           src_pattern,
   input  logic [3:0]            src_fg,
   input  logic [3:0]            src_bg,
   input  logic [2:0]            src_attr,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [63:0]           wr_data,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(COLUMNS - 1);

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] col;
   logic                  handshake;
   logic [63:0]           word;
   logic [3:0]            ink;
   logic [3:0]            paper;
   logic                  blank;
   logic                  on;

   // Derived from state directly so the handshake does not loop through src_ready.
   assign handshake = src_valid && (state == FETCH);

   // Underline forces ink, blink-off then suppresses it, invert swaps colours last.
   always_comb begin
      word  = '0;
      on    = 1'b0;
      ink   = src_attr[0] ? src_bg : src_fg;
      paper = src_attr[0] ? src_fg : src_bg;
      blank = src_attr[2] && blink_phase;
      for (int unsigned k = 0; k < 16; k++) begin
         on = (src_pattern[15-k] || src_attr[1]) && !blank;
         word[4*k +: 4] = on ? ink : paper;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      src_ready  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = FETCH;
         end
         FETCH: begin
            src_ready = 1'b1;
            busy      = 1'b1;
            if (handshake && (col == LAST_COL)) state_next = DRAIN;
         end
         DRAIN: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col     <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= handshake;
         if (handshake) begin
            wr_addr <= col;
            wr_data <= word;
         end
         if ((state == IDLE) && start) begin
            col <= '0;
         end else if (handshake && (col != LAST_COL)) begin
            col <= col + 1'b1;
         end
      end
   end

endmodule
